// File: rtl/fifo_byte_serializer_if.sv
// fifo_byte_serializer_if: upstream FIFO read port plus the downstream
// byte valid/ready handshake and status of the byte serializer.
interface fifo_byte_serializer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 en;
    logic                 EMPTY;
    logic [31:0]          fifoData;
    logic                 rd;
    logic [7:0]           byteOut;
    logic                 byteValid;
    logic                 byteReady;
    logic                 busy;
    logic [CNT_WIDTH-1:0] wordCount;

    // serializer side
    modport master (
        input  en, EMPTY, fifoData, byteReady,
        output rd, byteOut, byteValid, busy, wordCount
    );

    // FIFO / consumer / control side
    modport slave (
        output en, EMPTY, fifoData, byteReady,
        input  rd, byteOut, byteValid, busy, wordCount
    );
endinterface

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer: pops 32-bit words from a FIFO and emits them
// MSB byte first over a valid/ready byte channel, counting whole words.
module fifo_byte_serializer #(
    parameter int CNT_WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst,
    fifo_byte_serializer_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        LOAD,
        SEND
    } state_t;

    state_t               state;
    logic                 rd_q;
    logic                 valid_q;
    logic                 busy_q;
    logic [31:0]          sreg;
    logic [1:0]           idx;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 fetch;

    // a new word may be fetched only when enabled and the FIFO has data
    assign fetch = bus.en && !bus.EMPTY;

    assign bus.rd        = rd_q;
    assign bus.byteValid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.byteOut   = sreg[31:24];
    assign bus.wordCount = cnt;

    // control FSM with registered rd/byteValid/busy and the byte datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            sreg    <= 32'h0;
            idx     <= 2'd0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch) begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                READ: begin
                    // single-cycle strobe; the word shows up during LOAD
                    state <= LOAD;
                    rd_q  <= 1'b0;
                end
                LOAD: begin
                    state   <= SEND;
                    sreg    <= bus.fifoData;
                    idx     <= 2'd0;
                    valid_q <= 1'b1;
                end
                SEND: begin
                    // nothing moves while the consumer stalls
                    if (bus.byteReady) begin
                        sreg <= {sreg[23:0], 8'h00};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            cnt     <= cnt + CNT_WIDTH'(1);
                            valid_q <= 1'b0;
                            if (fetch) begin
                                state <= READ;
                                rd_q  <= 1'b1;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    rd_q    <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer: randomized bench with a queue-based FIFO and
// a byte-stream reference model for the byte serializer.
module tb_fifo_byte_serializer;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.CNT_WIDTH(CW)) bif ();

    fifo_byte_serializer #(.CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]   fq[$];
    logic [7:0]    exp_b[$];
    logic [7:0]    obs[$];
    int            xcyc[$];
    bit            rdy_pat[$];
    logic [CW-1:0] wc_exp;

    int   cyc = 0;
    int   rd_cnt = 0;
    int   rd_bad = 0;
    int   stall_bad = 0;
    int   underflow = 0;
    int   rdy_mode = 0;
    bit   rd_prev = 0;
    bit   stall_prev = 0;
    logic [7:0] stall_byte;

    // queue a word in the FIFO and its bytes, MSB first, in the model
    function automatic void add_word(input logic [31:0] w);
        fq.push_back(w);
        for (int k = 3; k >= 0; k--) exp_b.push_back(w[8*k +: 8]);
    endfunction

    function automatic void clear_model();
        exp_b.delete();
        obs.delete();
        xcyc.delete();
    endfunction

    // one clock: FIFO model, consumer model and protocol monitor
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rd_prev) begin
            if (fq.size() == 0) begin
                underflow++;
                bif.fifoData = $urandom;
            end else begin
                bif.fifoData = fq.pop_front();
            end
        end else begin
            bif.fifoData = $urandom;
        end
        bif.EMPTY = (fq.size() == 0);
        if (bif.rd === 1'b1) begin
            rd_cnt++;
            if (rd_prev) rd_bad++;
        end
        rd_prev = (bif.rd === 1'b1);
        if (stall_prev) begin
            if (bif.byteValid !== 1'b1 || bif.byteOut !== stall_byte)
                stall_bad++;
        end
        case (rdy_mode)
            0: bif.byteReady = 1'b1;
            1: begin
                if (bif.byteValid === 1'b1 && rdy_pat.size() > 0)
                    bif.byteReady = rdy_pat.pop_front();
                else
                    bif.byteReady = 1'b1;
            end
            default: bif.byteReady = 1'($urandom_range(0, 1));
        endcase
        if (bif.byteValid === 1'b1 && bif.byteReady === 1'b1) begin
            obs.push_back(bif.byteOut);
            xcyc.push_back(cyc);
        end
        stall_prev = (bif.byteValid === 1'b1) && !bif.byteReady;
        stall_byte = bif.byteOut;
    endtask

    task automatic run_until_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (bif.busy === 1'b0 && !rd_prev &&
                (bif.en === 1'b0 || fq.size() == 0)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        bif.en = 1'b0;
        bif.EMPTY = 1'b1;
        bif.byteReady = 1'b0;
        bif.fifoData = 32'h0;
        rst = 1'b0;
        #12;
        vectors += 5;
        if (bif.rd !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rd got %b want 0", bif.rd);
        end
        if (bif.byteValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid got %b want 0", bif.byteValid);
        end
        if (bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy got %b want 0", bif.busy);
        end
        if (bif.byteOut !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_byte got %h want 00", bif.byteOut);
        end
        if (bif.wordCount !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_count got %h want 0", bif.wordCount);
        end
        clear_model();
        wc_exp = '0;
        add_word(32'h5A6B7C8D);
        bif.en = 1'b1;
        bif.EMPTY = 1'b0;
        bif.byteReady = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (bif.rd !== 1'b1) begin
            miscompares++;
            $display("FAIL release_rd got %b want 1", bif.rd);
        end
        run_until_idle(50, ok);
        wc_exp = wc_exp + 4'(1);
        vectors += 3;
        if (!ok) begin
            miscompares++;
            $display("FAIL release_timeout got busy want idle");
        end
        if (obs.size() != exp_b.size()) begin
            miscompares++;
            $display("FAIL release_len got %0d want %0d",
                     obs.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL release_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL release_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
    endtask

    task automatic test_stream();
        bit ok;
        bit gap_ok;
        int rd0;
        clear_model();
        rdy_mode = 0;
        rd0 = rd_cnt;
        for (int w = 1; w <= 4; w++) add_word(32'(w));
        bif.en = 1'b1;
        run_until_idle(200, ok);
        wc_exp = wc_exp + 4'(4);
        vectors += 6;
        if (!ok) begin
            miscompares++;
            $display("FAIL stream_timeout got busy want idle");
        end
        if (obs.size() != 16) begin
            miscompares++;
            $display("FAIL stream_len got %0d want 16", obs.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL stream_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL stream_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
        if (rd_cnt - rd0 != 4) begin
            miscompares++;
            $display("FAIL stream_rd got %0d want 4", rd_cnt - rd0);
        end
        if (bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_busy got %b want 0", bif.busy);
        end
        gap_ok = (xcyc.size() == 16);
        for (int i = 1; i < xcyc.size(); i++)
            if (xcyc[i] - xcyc[i-1] != ((i % 4 == 0) ? 3 : 1))
                gap_ok = 1'b0;
        if (!gap_ok) begin
            miscompares++;
            $display("FAIL stream_spacing got irregular want 1/3 cycles");
        end
    endtask

    task automatic test_stall();
        bit ok;
        int s0;
        clear_model();
        s0 = stall_bad;
        rdy_mode = 1;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        add_word(32'hA1B2C3D4);
        run_until_idle(60, ok);
        wc_exp = wc_exp + 4'(1);
        vectors += 5;
        if (!ok) begin
            miscompares++;
            $display("FAIL stall_timeout got busy want idle");
        end
        if (obs.size() != 4) begin
            miscompares++;
            $display("FAIL stall_len got %0d want 4", obs.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL stall_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (stall_bad != s0) begin
            miscompares++;
            $display("FAIL stall_stable got %0d moves want 0",
                     stall_bad - s0);
        end
        if (xcyc.size() == 4 && xcyc[3] - xcyc[0] != 6) begin
            miscompares++;
            $display("FAIL stall_span got %0d want 6", xcyc[3] - xcyc[0]);
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL stall_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
        rdy_mode = 0;
    endtask

    task automatic test_en_gate();
        bit ok;
        int rd0;
        clear_model();
        rd0 = rd_cnt;
        bif.en = 1'b0;
        add_word($urandom);
        for (int i = 0; i < 20; i++) tick();
        vectors += 2;
        if (rd_cnt != rd0) begin
            miscompares++;
            $display("FAIL gate_rd got %0d pulses want 0", rd_cnt - rd0);
        end
        if (bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL gate_busy got %b want 0", bif.busy);
        end
        bif.en = 1'b1;
        tick();
        vectors++;
        if (bif.rd !== 1'b1) begin
            miscompares++;
            $display("FAIL gate_start got rd=%b want 1", bif.rd);
        end
        run_until_idle(50, ok);
        wc_exp = wc_exp + 4'(1);
        vectors += 2;
        if (!ok) begin
            miscompares++;
            $display("FAIL gate_timeout got busy want idle");
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL gate_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL gate_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
    endtask

    task automatic test_en_drop();
        bit ok;
        int rd0;
        int rd1;
        logic [7:0] want[$];
        clear_model();
        rd0 = rd_cnt;
        add_word(32'h11223344);
        fq.push_back(32'h55667788);
        want = exp_b;
        bif.en = 1'b1;
        for (int i = 0; i < 30 && obs.size() < 2; i++) tick();
        bif.en = 1'b0;
        run_until_idle(50, ok);
        wc_exp = wc_exp + 4'(1);
        vectors += 5;
        if (!ok) begin
            miscompares++;
            $display("FAIL drop_timeout got busy want idle");
        end
        if (obs.size() != 4) begin
            miscompares++;
            $display("FAIL drop_len got %0d want 4", obs.size());
        end
        for (int i = 0; i < want.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== want[i]) begin
                miscompares++;
                $display("FAIL drop_byte%0d got %h want %h",
                         i, obs[i], want[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL drop_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
        if (fq.size() != 1) begin
            miscompares++;
            $display("FAIL drop_fifo got %0d left want 1", fq.size());
        end
        rd1 = rd_cnt;
        for (int i = 0; i < 5; i++) tick();
        if (rd_cnt - rd0 != 1 || rd_cnt != rd1) begin
            miscompares++;
            $display("FAIL drop_rd got %0d pulses want 1", rd_cnt - rd0);
        end
        fq.delete();
        tick();
    endtask

    task automatic test_random();
        bit ok;
        int rd0;
        int u0;
        int s0;
        clear_model();
        rd0 = rd_cnt;
        u0 = underflow + rd_bad;
        s0 = stall_bad;
        rdy_mode = 2;
        for (int w = 0; w < 6; w++) add_word($urandom);
        bif.en = 1'b1;
        run_until_idle(600, ok);
        wc_exp = wc_exp + 4'(6);
        vectors += 6;
        if (!ok) begin
            miscompares++;
            $display("FAIL rand_timeout got busy want idle");
        end
        if (obs.size() != exp_b.size()) begin
            miscompares++;
            $display("FAIL rand_len got %0d want %0d",
                     obs.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL rand_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL rand_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
        if (rd_cnt - rd0 != 6) begin
            miscompares++;
            $display("FAIL rand_rd got %0d want 6", rd_cnt - rd0);
        end
        if (underflow + rd_bad != u0) begin
            miscompares++;
            $display("FAIL rand_rdproto got %0d bad reads want 0",
                     underflow + rd_bad - u0);
        end
        if (stall_bad != s0) begin
            miscompares++;
            $display("FAIL rand_stable got %0d moves want 0",
                     stall_bad - s0);
        end
        rdy_mode = 0;
    endtask

    task automatic test_midword_reset();
        bit ok;
        clear_model();
        fq.push_back(32'hCAFEBABE);
        bif.en = 1'b1;
        for (int i = 0; i < 30 && obs.size() < 2; i++) tick();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        vectors += 5;
        if (bif.byteValid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_valid got %b want 0", bif.byteValid);
        end
        if (bif.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_busy got %b want 0", bif.busy);
        end
        if (bif.rd !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rd got %b want 0", bif.rd);
        end
        if (bif.byteOut !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_byte got %h want 00", bif.byteOut);
        end
        if (bif.wordCount !== 4'h0) begin
            miscompares++;
            $display("FAIL mid_count got %h want 0", bif.wordCount);
        end
        clear_model();
        wc_exp = '0;
        add_word(32'h0BADF00D);
        @(negedge clk);
        rd_prev = 1'b0;
        stall_prev = 1'b0;
        bif.EMPTY = 1'b0;
        rst = 1'b1;
        run_until_idle(50, ok);
        wc_exp = wc_exp + 4'(1);
        vectors += 3;
        if (!ok) begin
            miscompares++;
            $display("FAIL mid_timeout got busy want idle");
        end
        if (obs.size() != 4) begin
            miscompares++;
            $display("FAIL mid_len got %0d want 4", obs.size());
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL mid_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
        if (bif.wordCount !== wc_exp) begin
            miscompares++;
            $display("FAIL mid_after_count got %h want %h",
                     bif.wordCount, wc_exp);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rd_prev = 1'b0;
        stall_prev = 1'b0;
        wc_exp = '0;
        clear_model();
        bif.en = 1'b1;
        for (int w = 0; w < 15; w++) add_word($urandom);
        run_until_idle(800, ok);
        wc_exp = wc_exp + 4'(15);
        vectors += 3;
        if (!ok) begin
            miscompares++;
            $display("FAIL wrap15_timeout got busy want idle");
        end
        if (bif.wordCount !== 4'hF || wc_exp !== 4'hF) begin
            miscompares++;
            $display("FAIL wrap15_count got %h want F", bif.wordCount);
        end
        if (obs.size() != 60) begin
            miscompares++;
            $display("FAIL wrap15_len got %0d want 60", obs.size());
        end
        for (int w = 0; w < 2; w++) add_word($urandom);
        run_until_idle(200, ok);
        wc_exp = wc_exp + 4'(2);
        vectors += 2;
        if (!ok) begin
            miscompares++;
            $display("FAIL wrap17_timeout got busy want idle");
        end
        if (bif.wordCount !== 4'h1 || wc_exp !== 4'h1) begin
            miscompares++;
            $display("FAIL wrap17_count got %h want 1", bif.wordCount);
        end
        for (int i = 0; i < exp_b.size() && i < obs.size(); i++) begin
            vectors++;
            if (obs[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL wrap_byte%0d got %h want %h",
                         i, obs[i], exp_b[i]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_en_gate();
        test_en_drop();
        test_random();
        test_midword_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
